// File: rtl/spi_pkg.sv
// Shared definitions for the SPI responder: one-hot FSM encoding and the
// SPI mode constants that pick which SCK edge samples and which one shifts.
package spi_pkg;

    typedef enum logic [2:0] {
        STATE_RESYNC = 3'b001,
        STATE_IDLE   = 3'b010,
        STATE_ACTIVE = 3'b100
    } state_t;

    localparam bit SPI_CPOL = 1'b0;
    localparam bit SPI_CPHA = 1'b0;

    // With CPOL == CPHA the rising SCK edge samples and the falling edge shifts.
    localparam bit SPI_SAMPLE_ON_RISE = (SPI_CPOL == SPI_CPHA);

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous pin, with registered one-cycle
// rise/fall pulses derived from the synchronized level.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_rise;
    logic                   r_fall;

    // NOTE: non-blocking assignments make each stage take the previous stage's
    // old value, so the chain really is SYNC_STAGES flops deep.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
            r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
            r_fall <= ~r_sync[SYNC_STAGES-1] & r_prev;
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];
    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/spi_peripheral.sv
// Mode-0 SPI responder: oversamples CS/SCK/MOSI in the clk domain, delivers
// complete frames as a valid/data pulse and shifts a host-loaded word on MISO.
module spi_peripheral
    import spi_pkg::*;
#(
    parameter int TRANSACTION_LENGTH_BITS = 32,
    parameter int SYNC_STAGES             = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               spi_cs_n,
    input  logic                               spi_clk,
    input  logic                               spi_din,
    output logic                               spi_dout,
    input  logic                               axiiv,
    input  logic [TRANSACTION_LENGTH_BITS-1:0] axiid,
    output logic                               axiready,
    output logic                               axiov,
    output logic [TRANSACTION_LENGTH_BITS-1:0] axiod,
    output logic                               frame_error
);

    localparam int              W          = TRANSACTION_LENGTH_BITS;
    localparam int              CW         = $clog2(W + 2);
    localparam logic [CW-1:0]   COUNT_FULL = CW'(W);
    localparam logic [CW-1:0]   COUNT_SAT  = CW'(W + 1);

    logic w_cs_sync, w_cs_rise, w_cs_fall;
    logic w_sck_sync, w_sck_rise, w_sck_fall;
    logic w_din;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (spi_cs_n),
        .o_sync  (w_cs_sync),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (spi_clk),
        .o_sync  (w_sck_sync),
        .o_rise  (w_sck_rise),
        .o_fall  (w_sck_fall)
    );

    // MOSI chain ends in a "previous" flop so it lines up with the registered SCK pulses.
    logic [SYNC_STAGES:0] r_din_sync;

    always_ff @(posedge clk) begin
        if (rst) r_din_sync <= '0;
        else     r_din_sync <= {r_din_sync[SYNC_STAGES-1:0], spi_din};
    end

    assign w_din = r_din_sync[SYNC_STAGES];

    state_t         r_state, w_state_next;
    logic [W-1:0]   r_rx_shift, r_tx_shift, r_tx_hold, r_axiod, w_tx_shift_next;
    logic [CW-1:0]  r_bit_count;
    logic           r_tx_pending, r_axiov, r_frame_error, r_dout;
    logic           w_frame_start, w_frame_end, w_sample, w_shift;

    always_ff @(posedge clk) begin
        if (rst) r_state <= STATE_RESYNC;
        else     r_state <= w_state_next;
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_next    = r_state;
        w_frame_start   = 1'b0;
        w_frame_end     = 1'b0;
        w_sample        = 1'b0;
        w_shift         = 1'b0;
        w_tx_shift_next = r_tx_shift;
        unique case (r_state)
            // Leave only once the bus is idle so a frame caught mid-way is dropped.
            STATE_RESYNC: if (w_cs_sync && (w_sck_sync == SPI_CPOL)) w_state_next = STATE_IDLE;
            STATE_IDLE: begin
                if (w_cs_fall) begin
                    w_state_next    = STATE_ACTIVE;
                    w_frame_start   = 1'b1;
                    w_tx_shift_next = r_tx_pending ? r_tx_hold : '0;
                end
            end
            STATE_ACTIVE: begin
                w_sample = SPI_SAMPLE_ON_RISE ? w_sck_rise : w_sck_fall;
                w_shift  = SPI_SAMPLE_ON_RISE ? w_sck_fall : w_sck_rise;
                if (w_shift) w_tx_shift_next = {r_tx_shift[W-2:0], 1'b0};
                if (w_cs_rise) begin
                    w_state_next = STATE_IDLE;
                    w_frame_end  = 1'b1;
                end
            end
            default: w_state_next = STATE_RESYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_shift    <= '0;
            r_tx_shift    <= '0;
            r_tx_hold     <= '0;
            r_tx_pending  <= 1'b0;
            r_bit_count   <= '0;
            r_axiod       <= '0;
            r_axiov       <= 1'b0;
            r_frame_error <= 1'b0;
            r_dout        <= 1'b0;
        end else begin
            r_axiov       <= 1'b0;
            r_frame_error <= 1'b0;
            r_tx_shift    <= w_tx_shift_next;
            r_dout        <= (w_state_next == STATE_ACTIVE) & w_tx_shift_next[W-1];

            if (w_frame_start) begin
                r_bit_count  <= '0;
                r_tx_pending <= 1'b0;
            end

            if (w_sample) begin
                r_rx_shift <= {r_rx_shift[W-2:0], w_din};
                if (r_bit_count != COUNT_SAT) r_bit_count <= r_bit_count + 1'b1;
            end

            if (w_frame_end) begin
                if (r_bit_count == COUNT_FULL) begin
                    r_axiod <= r_rx_shift;
                    r_axiov <= 1'b1;
                end else begin
                    r_frame_error <= 1'b1;
                end
            end

            // An accept in the same cycle as a frame start wins, keeping the new word pending.
            if (axiiv && !r_tx_pending) begin
                r_tx_hold    <= axiid;
                r_tx_pending <= 1'b1;
            end
        end
    end

    assign spi_dout    = r_dout;
    assign axiready    = ~r_tx_pending;
    assign axiov       = r_axiov;
    assign axiod       = r_axiod;
    assign frame_error = r_frame_error;

endmodule
